// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined signed-magnitude adder/subtractor with valid/ready flow control,
// per-result overflow flag, sticky overflow status and saturate-or-wrap overflow handling.
module sm_addsub_pipe #(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  // Q only locates the binary point; it must still fit inside the magnitude field.
  generate
    if (N < 4 || Q < 0 || Q > N - 1) begin : g_bad_params
      $error("sm_addsub_pipe: invalid N/Q parameters");
    end
  endgenerate

  logic         s1_valid_reg;
  logic [N-2:0] s1_big_reg;
  logic [N-2:0] s1_small_reg;
  logic         s1_sign_reg;
  logic         s1_sub_reg;

  logic         out_valid_reg;
  logic [N-1:0] c_reg;
  logic         ovf_reg;
  logic         ovf_sticky_reg;

  logic         s2_load;
  logic         s1_load;

  assign s2_load  = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  // Stage 1: effective signs, magnitude ordering.
  logic         sa;
  logic         sb;
  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic         a_ge_b;

  assign sa     = a[N-1];
  assign sb     = b[N-1] ^ op;
  assign ma     = a[N-2:0];
  assign mb     = b[N-2:0];
  assign a_ge_b = (ma >= mb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_big_reg   <= '0;
      s1_small_reg <= '0;
      s1_sign_reg  <= 1'b0;
      s1_sub_reg   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_big_reg   <= a_ge_b ? ma : mb;
        s1_small_reg <= a_ge_b ? mb : ma;
        s1_sign_reg  <= a_ge_b ? sa : sb;
        s1_sub_reg   <= sa ^ sb;
      end
    end
  end

  // Stage 2: magnitude arithmetic, overflow handling, and -0 suppression.
  logic [N-1:0] sum_full;
  logic [N-2:0] diff;
  logic [N-2:0] mag_raw;
  logic [N-2:0] mag_fix;
  logic         carry;
  logic         sign_fix;

  assign sum_full = {1'b0, s1_big_reg} + {1'b0, s1_small_reg};
  assign diff     = s1_big_reg - s1_small_reg;

  always_comb begin
    carry    = !s1_sub_reg && sum_full[N-1];
    mag_raw  = s1_sub_reg ? diff : sum_full[N-2:0];
    mag_fix  = (carry && SAT) ? {(N-1){1'b1}} : mag_raw;
    sign_fix = s1_sign_reg && (|mag_fix);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      ovf_reg       <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        c_reg   <= {sign_fix, mag_fix};
        ovf_reg <= carry;
      end
    end
  end

  // A set in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky_reg <= 1'b0;
    end else if (out_valid_reg && out_ready && ovf_reg) begin
      ovf_sticky_reg <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign c          = c_reg;
  assign ovf        = ovf_reg;
  assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe: a saturating and a wrapping instance share stimulus,
// results checked with immediate assertions against hand values and an integer model.
module tb_sm_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        op;
  logic        out_ready;
  logic        clr_sticky;
  logic [31:0] a;
  logic [31:0] b;

  logic        in_ready_s, out_valid_s, ovf_s, sticky_s;
  logic [31:0] c_s;
  logic        in_ready_w, out_valid_w, ovf_w, sticky_w;
  logic [31:0] c_w;

  int n_checks = 0;
  int n_fail   = 0;

  sm_addsub_pipe #(.N(32), .Q(15), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
    .c(c_s), .ovf(ovf_s), .ovf_sticky(sticky_s), .clr_sticky(clr_sticky)
  );

  sm_addsub_pipe #(.N(32), .Q(15), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .c(c_w), .ovf(ovf_w), .ovf_sticky(sticky_w), .clr_sticky(clr_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Signed integer reference: {ovf, c}
  function automatic logic [32:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                        input logic fop, input bit sat);
    longint va, vb, r, mag;
    logic   sgn, ov;
    va  = longint'({33'b0, fa[30:0]});
    vb  = longint'({33'b0, fb[30:0]});
    if (fa[31]) va = -va;
    if (fb[31] ^ fop) vb = -vb;
    r   = va + vb;
    sgn = (r < 0);
    mag = sgn ? -r : r;
    ov  = (mag > 64'h7FFF_FFFF);
    if (ov) mag = sat ? 64'h7FFF_FFFF : (mag & 64'h7FFF_FFFF);
    if (mag == 0) sgn = 1'b0;
    return {ov, sgn, mag[30:0]};
  endfunction

  // One isolated operation with out_ready high; checks both instances.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic top, input logic [31:0] exp_cs, input logic exp_os,
                        input logic [31:0] exp_cw, input logic exp_ow);
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'b0, out_valid_s}, 32'd1);
    chk({tag, "_c_sat"}, c_s, exp_cs);
    chk({tag, "_ovf_sat"}, {31'b0, ovf_s}, {31'b0, exp_os});
    chk({tag, "_c_wrap"}, c_w, exp_cw);
    chk({tag, "_ovf_wrap"}, {31'b0, ovf_w}, {31'b0, exp_ow});
  endtask

  logic [31:0] va_arr [8];
  logic [31:0] vb_arr [8];
  logic        vop_arr[8];
  logic [32:0] es_arr [8];
  logic [32:0] ew_arr [8];
  logic [3:0]  rdy_pat;

  initial begin
    int sent, recv, cyc;
    logic in_fire, stall, saw_block, exp_sticky;
    logic [31:0] hold_s, hold_w;

    rst = 1'b0; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0;
    #3;
    chk("reset_out_valid", {31'b0, out_valid_s}, 32'd0);
    chk("reset_c", c_s, 32'd0);
    chk("reset_ovf", {31'b0, ovf_s}, 32'd0);
    chk("reset_sticky", {31'b0, sticky_s}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", {31'b0, in_ready_s}, 32'd1);

    run_op("add_3p1", 32'h0001_8000, 32'h0000_8000, 1'b0, 32'h0002_0000, 1'b0, 32'h0002_0000, 1'b0);
    run_op("sub_3m1", 32'h0001_8000, 32'h0000_8000, 1'b1, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0);
    run_op("add_1pm3", 32'h0000_8000, 32'h8001_8000, 1'b0, 32'h8001_0000, 1'b0, 32'h8001_0000, 1'b0);
    run_op("sub_equal", 32'h0000_8000, 32'h0000_8000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    run_op("neg_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    run_op("sub_5mm3", 32'h0000_0005, 32'h8000_0003, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0008, 1'b0);
    run_op("add_m2p7", 32'h8000_0002, 32'h0000_0007, 1'b0, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    chk("sticky_before_xfer", {31'b0, sticky_s}, 32'd0);
    run_op("ovf_neg", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    chk("sticky_sat_set", {31'b0, sticky_s}, 32'd1);
    chk("sticky_wrap_set", {31'b0, sticky_w}, 32'd1);

    // ovf result transfers on the same edge as a clear: set wins, then clear takes effect.
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("sticky_set_wins", {31'b0, sticky_s}, 32'd1);
    @(posedge clk); #1;
    chk("sticky_cleared", {31'b0, sticky_s}, 32'd0);
    clr_sticky = 1'b0;

    // Back-pressure stream.
    exp_sticky = 1'b0;
    for (int i = 0; i < 8; i++) begin
      va_arr[i]  = $urandom;
      vb_arr[i]  = $urandom;
      vop_arr[i] = 1'($urandom_range(0, 1));
    end
    va_arr[0] = 32'h7FFF_FFF0; vb_arr[0] = 32'h0000_0100; vop_arr[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      es_arr[i] = model(va_arr[i], vb_arr[i], vop_arr[i], 1'b1);
      ew_arr[i] = model(va_arr[i], vb_arr[i], vop_arr[i], 1'b0);
      exp_sticky = exp_sticky | es_arr[i][32];
    end
    rdy_pat = 4'b1001;
    sent = 0; recv = 0; cyc = 0; saw_block = 1'b0;
    while (recv < 8 && cyc < 60) begin
      out_ready = rdy_pat[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = va_arr[sent]; b = vb_arr[sent]; op = vop_arr[sent];
      end
      #0;
      in_fire = in_valid && in_ready_s;
      if (!in_ready_s) saw_block = 1'b1;
      if (out_valid_s && out_ready) begin
        chk($sformatf("bp_c_sat_%0d", recv), c_s, es_arr[recv][31:0]);
        chk($sformatf("bp_ovf_sat_%0d", recv), {31'b0, ovf_s}, {31'b0, es_arr[recv][32]});
        chk($sformatf("bp_c_wrap_%0d", recv), c_w, ew_arr[recv][31:0]);
        recv++;
      end
      stall  = out_valid_s && !out_ready;
      hold_s = c_s;
      hold_w = c_w;
      @(posedge clk); #1;
      if (in_fire) sent++;
      if (stall) begin
        chk("bp_hold_valid", {31'b0, out_valid_s}, 32'd1);
        chk("bp_hold_c_sat", c_s, hold_s);
        chk("bp_hold_c_wrap", c_w, hold_w);
      end
      cyc++;
    end
    chk("bp_results_count", recv, 32'd8);
    chk("bp_in_ready_dropped", {31'b0, saw_block}, 32'd1);
    chk("bp_sticky", {31'b0, sticky_s}, {31'b0, exp_sticky});
    in_valid = 1'b0;

    // Fill both stages while stalled, then reset mid-flight.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'h0000_0011; b = 32'h0000_0022; op = 1'b0;
    @(posedge clk); #1;
    a = 32'h0000_0033; b = 32'h0000_0044;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_in_ready", {31'b0, in_ready_s}, 32'd0);
    chk("full_out_valid", {31'b0, out_valid_s}, 32'd1);
    chk("full_c", c_s, 32'h0000_0033);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid_s}, 32'd0);
    chk("midrst_c", c_s, 32'd0);
    chk("midrst_sticky", {31'b0, sticky_s}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready_s}, 32'd1);
    run_op("after_reset", 32'h0001_8000, 32'h8000_8000, 1'b0, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0);
    @(posedge clk); #1;
    chk("after_reset_drain", {31'b0, out_valid_s}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
